axi4_s_w: RTL and testbench
===========================

Name: axi4_s_w

Overview:
AXI4 slave write endpoint sitting directly downstream of the cosim AXI4 write master; consumes AW/W/B and converts each burst into per-beat strobed writes on a simple memory/register port. Used as the HDL-side target (BRAM/CSR model) for QEMU-originated writes. One outstanding burst at a time; B response carries captured AWID.

Parameters:
TAGW, 3, AXI ID width
ADRW, 32, address width
DATW, 256, data bus width (bits)
STBW, DATW/8, strobe width (bytes per beat)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_s_awid  in  TAGW  write ID
i_s_awaddr  in  ADRW  burst start address
i_s_awlen  in  8  beats-1
i_s_awsize  in  3  log2 bytes per beat
i_s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
i_s_awvalid  in  1  AW valid
o_s_awready  out  1  AW ready
i_s_wdata  in  DATW  write data
i_s_wstrb  in  STBW  byte strobes
i_s_wlast  in  1  last beat marker
i_s_wvalid  in  1  W valid
o_s_wready  out  1  W ready
o_s_bid  out  TAGW  response ID
o_s_bresp  out  2  00 OKAY, 10 SLVERR
o_s_bvalid  out  1  B valid
i_s_bready  in  1  B ready
o_wr_en  out  1  memory write strobe
o_wr_addr  out  ADRW  beat address
o_wr_data  out  DATW  beat data
o_wr_strb  out  STBW  beat byte enables
i_wr_ready  in  1  memory can accept beat

Behaviour:
- Reset i_rst_n, synchronous, active-low; clock i_clk. During reset: awready 0, wready 0, bvalid 0, bresp 0, bid 0, wr_en 0; state IDLE, beat counter 0, error flag 0.
- Reset mid-burst: burst discarded, no B issued, return to IDLE.
- States: IDLE, DATA, RESP.
- IDLE: awready=1. On awvalid&awready capture id/addr/len/size/burst, clear counter and error flag, go DATA next cycle. W beats are never accepted in IDLE.
- DATA: awready=0; wready = i_wr_ready. Beat handshake = wvalid&wready. o_wr_en = handshake & ~size_err & ~burst_err; wr_data/wr_strb pass through combinationally from W; wr_addr = current beat address register. Zero added latency.
- Address update per handshake: FIXED keeps address; INCR next = (addr & ~(2^size-1)) + 2^size, modulo 2^ADRW, no 4KB check; WRAP per Optional Feature.
- Beat counter governs burst end: on handshake with count==awlen go RESP; else count+1. wlast=1 on a non-final beat, or wlast=0 on the final beat, sets error flag; writes continue.
- size_err: awsize > log2(STBW); all beats drained, no writes.
- RESP: bvalid=1, bid=captured ID, bresp = SLVERR if any error flag else OKAY. Hold until bready; on handshake go IDLE (next AW accepted earliest one cycle after B handshake).
- awlen=0: single beat, RESP after one handshake.
- i_wr_ready low stalls wready; no beat lost or duplicated.

Optional Feature:
AXI4_S_W_WRAP_EN. Defined: WRAP supported, len must be 1/3/7/15 beats; address wraps within (len+1)*2^size aligned window; illegal len sets burst_err. Undefined: any WRAP burst sets burst_err; beats drained with no writes, bresp SLVERR. Burst 11 (reserved) is always burst_err.

Decomposition:
- Package axi4_pkg: burst enum (FIXED/INCR/WRAP), resp constants (OKAY/SLVERR), state enum, function size_bytes(size).
- Sub-module axi4_addr_gen: combinational next-address from addr/size/len/burst, plus wrap-legality flag; keeps arithmetic out of the FSM.

Test Plan:
- Single beat: AW id=5 addr=0x1000 len=0 size=5 INCR, W strb=0xFFFF_FFFF wlast=1 -> one wr_en at 0x1000, B id=5 resp=00.
- INCR 4 beats size=5 from 0x1010 -> wr_addr 0x1010, 0x1020, 0x1040, 0x1060; B OKAY after 4th beat.
- Backpressure: i_wr_ready low 3 cycles mid-burst of 4 -> wready low same cycles, exactly 4 wr_en pulses, addresses unchanged by stall.
- Early wlast on beat 1 of len=2 -> all 3 beats written, bresp=10.
- awsize=6 with DATW=256 -> no wr_en, 2 beats drained for len=1, bresp=10; bready held low 5 cycles -> bvalid stable, awready 0 until B handshake.
- WRAP len=3 size=5 addr=0x1060: with macro -> 0x1060, 0x1000, 0x1020, 0x1040 OKAY; without -> no writes, SLVERR.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared types and helpers for the AXI4 slave write endpoint.
// Burst encodings, response codes, FSM state constants and beat-size decode.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [7:0] size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// Next-beat address generator for FIXED/INCR/WRAP bursts plus WRAP legality.
// WRAP bursts are only legal when AXI4_S_W_WRAP_EN is defined.
module axi4_addr_gen
  import axi4_pkg::*;
#(
  parameter int unsigned ADRW = 32
) (
  input  logic [ADRW-1:0] addr,
  input  logic [2:0]      size,
  input  logic [7:0]      len,
  input  burst_e          burst,
  output logic [ADRW-1:0] next_addr,
  output logic            wrap_ok
);

  logic [ADRW-1:0] beat_bytes;
  logic [ADRW-1:0] aligned;
  logic [ADRW-1:0] incr_addr;
  logic [ADRW-1:0] win_mask;

  always_comb begin
    beat_bytes = ADRW'(size_bytes(size));
    aligned    = addr & ~(beat_bytes - ADRW'(1));
    incr_addr  = aligned + beat_bytes;
    // Wrap window is (len+1) beats, aligned to its own size
    win_mask   = ((ADRW'(len) + ADRW'(1)) << size) - ADRW'(1);

    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~win_mask) | (incr_addr & win_mask);
      default:    next_addr = addr;
    endcase

`ifdef AXI4_S_W_WRAP_EN
    wrap_ok = (len == 8'd1) | (len == 8'd3) | (len == 8'd7) | (len == 8'd15);
`else
    wrap_ok = 1'b0;
`endif
  end

endmodule

// File: rtl/axi4_s_w.sv
// AXI4 slave write endpoint: one burst at a time, per-beat strobed writes on a memory port.
// Optional WRAP burst support is enabled by defining AXI4_S_W_WRAP_EN.
module axi4_s_w
  import axi4_pkg::*;
#(
  parameter int unsigned TAGW = 3,
  parameter int unsigned ADRW = 32,
  parameter int unsigned DATW = 256,
  parameter int unsigned STBW = DATW/8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [TAGW-1:0] i_s_awid,
  input  logic [ADRW-1:0] i_s_awaddr,
  input  logic [7:0]      i_s_awlen,
  input  logic [2:0]      i_s_awsize,
  input  logic [1:0]      i_s_awburst,
  input  logic            i_s_awvalid,
  output logic            o_s_awready,
  input  logic [DATW-1:0] i_s_wdata,
  input  logic [STBW-1:0] i_s_wstrb,
  input  logic            i_s_wlast,
  input  logic            i_s_wvalid,
  output logic            o_s_wready,
  output logic [TAGW-1:0] o_s_bid,
  output logic [1:0]      o_s_bresp,
  output logic            o_s_bvalid,
  input  logic            i_s_bready,
  output logic            o_wr_en,
  output logic [ADRW-1:0] o_wr_addr,
  output logic [DATW-1:0] o_wr_data,
  output logic [STBW-1:0] o_wr_strb,
  input  logic            i_wr_ready
);

  localparam int unsigned MAX_SIZE = $clog2(STBW);

  logic [1:0]      state_q, state_d;
  logic [TAGW-1:0] id_q, id_d, bid_d;
  logic [ADRW-1:0] addr_q, addr_d, next_addr;
  logic [7:0]      len_q, len_d, cnt_q, cnt_d;
  logic [2:0]      size_q, size_d;
  burst_e          burst_q, burst_d;
  logic            err_q, err_d;
  logic [1:0]      bresp_d;
  logic            wrap_ok, size_err, burst_err;
  logic            aw_hs, w_hs, b_hs, last_beat;

  axi4_addr_gen #(.ADRW(ADRW)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .wrap_ok   (wrap_ok)
  );

  // Burst-level errors: the burst is drained but nothing reaches memory
  always_comb begin
    size_err  = 32'(size_q) > MAX_SIZE;
    burst_err = 1'b0;
    case (burst_q)
      BURST_FIXED, BURST_INCR: burst_err = 1'b0;
      BURST_WRAP:              burst_err = ~wrap_ok;
      default:                 burst_err = 1'b1;
    endcase
  end

  // Next-state and beat datapath
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bid_d   = o_s_bid;
    bresp_d = o_s_bresp;

    aw_hs      = i_s_awvalid & o_s_awready;
    o_s_wready = (state_q == ST_DATA) & i_wr_ready & i_rst_n;
    w_hs       = i_s_wvalid & o_s_wready;
    b_hs       = o_s_bvalid & i_s_bready;
    last_beat  = (cnt_q == len_q);
    o_wr_en    = w_hs & ~size_err & ~burst_err;
    o_wr_addr  = addr_q;
    o_wr_data  = i_s_wdata;
    o_wr_strb  = i_s_wstrb;

    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d    = i_s_awid;
          addr_d  = i_s_awaddr;
          len_d   = i_s_awlen;
          size_d  = i_s_awsize;
          burst_d = burst_e'(i_s_awburst);
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          addr_d = next_addr;
          if (i_s_wlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            state_d = ST_RESP;
            bid_d   = id_q;
            bresp_d = (err_d | size_err | burst_err) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= BURST_FIXED;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      o_s_awready <= 1'b0;
      o_s_bvalid  <= 1'b0;
      o_s_bid     <= '0;
      o_s_bresp   <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      o_s_awready <= (state_d == ST_IDLE);
      o_s_bvalid  <= (state_d == ST_RESP);
      o_s_bid     <= bid_d;
      o_s_bresp   <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_s_w.sv
// Bench for axi4_s_w: directed vector table, reset corner cases, randomized bursts vs a model.
`timescale 1ns/1ps
module tb_axi4_s_w;

  localparam int unsigned TAGW = 3;
  localparam int unsigned ADRW = 32;
  localparam int unsigned DATW = 256;
  localparam int unsigned STBW = DATW/8;
`ifdef AXI4_S_W_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [TAGW-1:0] s_awid = '0;
  logic [ADRW-1:0] s_awaddr = '0;
  logic [7:0]      s_awlen = '0;
  logic [2:0]      s_awsize = '0;
  logic [1:0]      s_awburst = '0;
  logic            s_awvalid = 1'b0;
  logic [DATW-1:0] s_wdata = '0;
  logic [STBW-1:0] s_wstrb = '0;
  logic            s_wlast = 1'b0;
  logic            s_wvalid = 1'b0;
  logic            s_bready = 1'b0;
  logic            wr_ready = 1'b0;
  logic            o_s_awready, o_s_wready, o_s_bvalid, o_wr_en;
  logic [TAGW-1:0] o_s_bid;
  logic [1:0]      o_s_bresp;
  logic [ADRW-1:0] o_wr_addr;
  logic [DATW-1:0] o_wr_data;
  logic [STBW-1:0] o_wr_strb;

  always #5 clk = ~clk;

  axi4_s_w dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_s_awid    (s_awid),
    .i_s_awaddr  (s_awaddr),
    .i_s_awlen   (s_awlen),
    .i_s_awsize  (s_awsize),
    .i_s_awburst (s_awburst),
    .i_s_awvalid (s_awvalid),
    .o_s_awready (o_s_awready),
    .i_s_wdata   (s_wdata),
    .i_s_wstrb   (s_wstrb),
    .i_s_wlast   (s_wlast),
    .i_s_wvalid  (s_wvalid),
    .o_s_wready  (o_s_wready),
    .o_s_bid     (o_s_bid),
    .o_s_bresp   (o_s_bresp),
    .o_s_bvalid  (o_s_bvalid),
    .i_s_bready  (s_bready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_wr_strb   (o_wr_strb),
    .i_wr_ready  (wr_ready)
  );

  typedef struct packed {
    logic [2:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [1:0]       wl_mode;   // 0 normal, 1 extra wlast at wl_idx, 2 never wlast
    logic [7:0]       wl_idx;
    logic [7:0]       stall_beat;
    logic [7:0]       stall_cyc;
    logic [7:0]       bdly;
    logic [7:0]       exp_n;
    logic [3:0][31:0] exp_a;
    logic [1:0]       exp_resp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] act_q[$];
  logic [2:0]  got_bid;
  logic [1:0]  got_bresp;
  bit          got_b;
  vec_t        vt[12];

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] id, input logic [31:0] a, input logic [7:0] len,
                              input logic [2:0] sz, input logic [1:0] bu, input logic [1:0] wm,
                              input logic [7:0] wi, input logic [7:0] sb, input logic [7:0] sc,
                              input logic [7:0] bd, input logic [7:0] n, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3,
                              input logic [1:0] r);
    vec_t v;
    v.id = id; v.addr = a; v.len = len; v.size = sz; v.burst = bu;
    v.wl_mode = wm; v.wl_idx = wi; v.stall_beat = sb; v.stall_cyc = sc; v.bdly = bd;
    v.exp_n = n; v.exp_a = {a3, a2, a1, a0}; v.exp_resp = r;
    return v;
  endfunction

  // Reference: address of beat i from the AXI burst rules
  function automatic logic [31:0] mdl_addr(input logic [31:0] a, input int unsigned len,
                                           input int unsigned size, input int unsigned burst,
                                           input int unsigned i);
    longint unsigned nb, al, win, base;
    nb = 64'(1) << size;
    al = (64'(a) / nb) * nb;
    if (i == 0 || burst == 0) return a;
    if (burst == 1) return 32'(al + 64'(i) * nb);
    win  = 64'(len + 1) * nb;
    base = (64'(a) / win) * win;
    return 32'(base + ((al - base) + 64'(i) * nb) % win);
  endfunction

  function automatic bit mdl_cfg_err(input int unsigned len, input int unsigned size,
                                     input int unsigned burst);
    bit wrap_legal;
    wrap_legal = WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15);
    return (size > 5) || (burst == 3) || (burst == 2 && !wrap_legal);
  endfunction

  task automatic run_burst(input logic [2:0] id, input logic [31:0] addr, input int unsigned len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int unsigned wl_mode, input int unsigned wl_idx,
                           input int unsigned stall_beat, input int unsigned stall_cyc,
                           input int unsigned bdly, input bit rnd);
    int unsigned beat, cyc, stall_left, dly;
    bit done, wv, wrr, hs;
    logic [DATW-1:0] d;
    logic [STBW-1:0] s;
    act_q.delete();
    got_b = 1'b0;
    // Address phase; W presented alongside must not be taken while idle
    done = 1'b0; cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awsize = size; s_awburst = burst;
      s_awvalid = 1'b1; s_wvalid = 1'b1; wr_ready = 1'b1; s_wlast = 1'b1;
      #1;
      chk(!o_s_wready, "wready_idle", 32'(o_s_wready), 32'(0));
      chk(!o_wr_en, "wr_en_idle", 32'(o_wr_en), 32'(0));
      done = o_s_awready;
      cyc++;
    end
    if (!done) begin
      chk(1'b0, "aw_timeout", cyc, 50);
      return;
    end
    // Data phase
    beat = 0; cyc = 0; stall_left = stall_cyc;
    while (beat <= len && cyc < 400) begin
      @(negedge clk);
      s_awvalid = 1'b0;
      if (rnd) begin
        wv  = ($urandom_range(0, 4) != 0);
        wrr = ($urandom_range(0, 3) != 0);
      end else begin
        wv  = 1'b1;
        wrr = !(beat == stall_beat && stall_left > 0);
        if (!wrr) stall_left--;
      end
      for (int k = 0; k < DATW/32; k++) d[k*32 +: 32] = $urandom;
      s = STBW'($urandom);
      s_wvalid = wv; s_wdata = d; s_wstrb = s; wr_ready = wrr;
      s_wlast = (wl_mode == 2) ? 1'b0 : ((beat == len) || (wl_mode == 1 && beat == wl_idx));
      #1;
      chk(o_s_wready == wrr, "wready_follow", 32'(o_s_wready), 32'(wrr));
      chk(!o_s_awready, "awready_data", 32'(o_s_awready), 32'(0));
      hs = wv & wrr;
      if (o_wr_en) begin
        chk(hs, "wr_en_without_hs", 32'(o_wr_en), 32'(hs));
        chk(o_wr_data == d, "wr_data", o_wr_data[31:0], d[31:0]);
        chk(o_wr_strb == s, "wr_strb", o_wr_strb, s);
        act_q.push_back(o_wr_addr);
      end
      if (hs) beat++;
      cyc++;
    end
    if (beat <= len) begin
      chk(1'b0, "w_timeout", beat, len + 1);
      return;
    end
    // Response phase
    dly = bdly; done = 1'b0; cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      s_wvalid = 1'b0; s_wlast = 1'b0; wr_ready = 1'b0;
      s_bready = (dly == 0);
      #1;
      if (o_s_bvalid) begin
        if (!got_b) begin
          got_b = 1'b1; got_bid = o_s_bid; got_bresp = o_s_bresp;
        end else begin
          chk(o_s_bid == got_bid && o_s_bresp == got_bresp, "b_stable",
              32'({o_s_bid, o_s_bresp}), 32'({got_bid, got_bresp}));
        end
        chk(!o_s_awready, "awready_resp", 32'(o_s_awready), 32'(0));
        if (s_bready) done = 1'b1;
        else dly--;
      end
      cyc++;
    end
    chk(done, "b_timeout", cyc, 100);
    @(negedge clk);
    s_bready = 1'b0;
    #1;
    chk(!o_s_bvalid, "bvalid_after_b", 32'(o_s_bvalid), 32'(0));
    chk(o_s_awready, "awready_after_b", 32'(o_s_awready), 32'(1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(3'd5, 32'h1000, 8'd0, 3'd5, 2'd1, 2'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd1, 32'h1000, 32'h0, 32'h0, 32'h0, 2'b00);
    vt[1]  = mk(3'd2, 32'h1010, 8'd3, 3'd5, 2'd1, 2'd0, 8'd0, 8'd255, 8'd0, 8'd1,
                8'd4, 32'h1010, 32'h1020, 32'h1040, 32'h1060, 2'b00);
    vt[2]  = mk(3'd3, 32'h2000, 8'd3, 3'd5, 2'd1, 2'd0, 8'd0, 8'd2, 8'd3, 8'd0,
                8'd4, 32'h2000, 32'h2020, 32'h2040, 32'h2060, 2'b00);
    vt[3]  = mk(3'd1, 32'h3000, 8'd2, 3'd5, 2'd1, 2'd1, 8'd1, 8'd255, 8'd0, 8'd0,
                8'd3, 32'h3000, 32'h3020, 32'h3040, 32'h0, 2'b10);
    vt[4]  = mk(3'd6, 32'h4000, 8'd1, 3'd6, 2'd1, 2'd0, 8'd0, 8'd255, 8'd0, 8'd5,
                8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10);
`ifdef AXI4_S_W_WRAP_EN
    vt[5]  = mk(3'd7, 32'h1060, 8'd3, 3'd5, 2'd2, 2'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd4, 32'h1060, 32'h1000, 32'h1020, 32'h1040, 2'b00);
`else
    vt[5]  = mk(3'd7, 32'h1060, 8'd3, 3'd5, 2'd2, 2'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10);
`endif
    vt[6]  = mk(3'd0, 32'h5004, 8'd2, 3'd2, 2'd0, 2'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd3, 32'h5004, 32'h5004, 32'h5004, 32'h0, 2'b00);
    vt[7]  = mk(3'd4, 32'h5100, 8'd1, 3'd2, 2'd3, 2'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10);
    vt[8]  = mk(3'd2, 32'h6003, 8'd2, 3'd2, 2'd1, 2'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd3, 32'h6003, 32'h6004, 32'h6008, 32'h0, 2'b00);
    vt[9]  = mk(3'd3, 32'hFFFF_FFE0, 8'd1, 3'd5, 2'd1, 2'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd2, 32'hFFFF_FFE0, 32'h0, 32'h0, 32'h0, 2'b00);
    vt[10] = mk(3'd1, 32'h7000, 8'd1, 3'd5, 2'd1, 2'd2, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd2, 32'h7000, 32'h7020, 32'h0, 32'h0, 2'b10);
    vt[11] = mk(3'd5, 32'h1040, 8'd2, 3'd5, 2'd2, 2'd0, 8'd0, 8'd255, 8'd0, 8'd0,
                8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10);

    // Reset with live inputs: everything must stay quiet
    s_awvalid = 1'b1; s_wvalid = 1'b1; wr_ready = 1'b1; s_bready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk(!o_s_awready, "rst_awready", 32'(o_s_awready), 32'(0));
    chk(!o_s_wready, "rst_wready", 32'(o_s_wready), 32'(0));
    chk(!o_s_bvalid, "rst_bvalid", 32'(o_s_bvalid), 32'(0));
    chk(o_s_bid == 3'd0, "rst_bid", 32'(o_s_bid), 32'(0));
    chk(o_s_bresp == 2'd0, "rst_bresp", 32'(o_s_bresp), 32'(0));
    chk(!o_wr_en, "rst_wr_en", 32'(o_wr_en), 32'(0));
    s_awvalid = 1'b0; s_wvalid = 1'b0; wr_ready = 1'b0; s_bready = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      run_burst(vt[k].id, vt[k].addr, int'(vt[k].len), vt[k].size, vt[k].burst,
                int'(vt[k].wl_mode), int'(vt[k].wl_idx), int'(vt[k].stall_beat),
                int'(vt[k].stall_cyc), int'(vt[k].bdly), 1'b0);
      chk(act_q.size() == int'(vt[k].exp_n), $sformatf("v%0d_n_writes", k),
          32'(act_q.size()), 32'(vt[k].exp_n));
      for (int i = 0; i < 4; i++)
        if (i < int'(vt[k].exp_n) && i < act_q.size())
          chk(act_q[i] == vt[k].exp_a[i], $sformatf("v%0d_addr%0d", k, i), act_q[i], vt[k].exp_a[i]);
      chk(got_b, $sformatf("v%0d_b_seen", k), 32'(got_b), 32'(1));
      chk(got_bresp == vt[k].exp_resp, $sformatf("v%0d_bresp", k), 32'(got_bresp), 32'(vt[k].exp_resp));
      chk(got_bid == vt[k].id, $sformatf("v%0d_bid", k), 32'(got_bid), 32'(vt[k].id));
    end

    // Reset in the middle of a 4-beat burst: burst dropped, no B, back to idle
    @(negedge clk);
    s_awid = 3'd4; s_awaddr = 32'h8000; s_awlen = 8'd3; s_awsize = 3'd5; s_awburst = 2'd1;
    s_awvalid = 1'b1;
    #1;
    chk(o_s_awready, "mid_awready", 32'(o_s_awready), 32'(1));
    repeat (2) begin
      @(negedge clk);
      s_awvalid = 1'b0; s_wvalid = 1'b1; wr_ready = 1'b1; s_wlast = 1'b0;
      #1;
      chk(o_wr_en, "mid_beat_written", 32'(o_wr_en), 32'(1));
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(!o_s_wready && !o_wr_en, "mid_rst_quiet", 32'({o_s_wready, o_wr_en}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1; s_wvalid = 1'b0; wr_ready = 1'b0; s_bready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk(!o_s_bvalid, "mid_no_b", 32'(o_s_bvalid), 32'(0));
    end
    chk(o_s_awready, "mid_idle_again", 32'(o_s_awready), 32'(1));
    s_bready = 1'b0;

    // Randomized bursts against the reference model
    for (int n = 0; n < 40; n++) begin
      int unsigned len, sz, bu, wm, wi, nexp;
      logic [31:0] a;
      logic [2:0]  idv;
      bit          cerr, lerr;
      bu  = $urandom_range(0, 3);
      sz  = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
      if (bu == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else len = $urandom_range(0, 15);
      a = $urandom;
      if (bu == 2) a = a & ~((32'd1 << sz) - 32'd1);
      wm  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      wi  = $urandom_range(0, len);
      idv = 3'($urandom);
      run_burst(idv, a, len, 3'(sz), 2'(bu), wm, wi, 255, 0, $urandom_range(0, 3), 1'b1);
      cerr = mdl_cfg_err(len, sz, bu);
      lerr = (wm == 2) || (wm == 1 && wi < len);
      nexp = cerr ? 0 : len + 1;
      chk(act_q.size() == int'(nexp), "rnd_n_writes", 32'(act_q.size()), nexp);
      for (int i = 0; i < act_q.size() && i < int'(nexp); i++)
        chk(act_q[i] == mdl_addr(a, len, sz, bu, i), $sformatf("rnd%0d_addr%0d", n, i),
            act_q[i], mdl_addr(a, len, sz, bu, i));
      chk(got_bresp == ((cerr || lerr) ? 2'b10 : 2'b00), "rnd_bresp",
          32'(got_bresp), (cerr || lerr) ? 32'd2 : 32'd0);
      chk(got_bid == idv, "rnd_bid", 32'(got_bid), 32'(idv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
